// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_module master between NUM_REQ requesters.
// One transaction in flight at a time; a watchdog abandons transfers that never interrupt.
module spi_txn_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int CFG_W   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                      i_sys_clk,
   input  logic                      i_sys_rst,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   input  logic [NUM_REQ*CFG_W-1:0]  i_req_cfg,
   output logic [NUM_REQ-1:0]        o_req_ready,
   output logic [NUM_REQ-1:0]        o_rsp_valid,
   output logic [DATA_W-1:0]         o_rsp_data,
   output logic                      o_rsp_err,
   output logic                      o_busy,
   output logic [DATA_W-1:0]         o_spi_data,
   output logic [CFG_W-1:0]          o_spi_config,
   output logic                      o_spi_trans_en,
   input  logic                      i_spi_interrupt,
   input  logic [DATA_W-1:0]         i_spi_data
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [IDX_W:0]       NREQ_X   = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_REQ-1);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT-1);
   localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_SETUP,
      S_BUSY,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  ready_q, ready_d;
   logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   spi_data_q, spi_data_d;
   logic [CFG_W-1:0]    spi_cfg_q, spi_cfg_d;
   logic                trans_en_q, trans_en_d;

   logic [DATA_W-1:0]   req_data [NUM_REQ];
   logic [CFG_W-1:0]    req_cfg  [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign req_data[k] = i_req_data[k*DATA_W +: DATA_W];
      assign req_cfg[k]  = i_req_cfg[k*CFG_W +: CFG_W];
   end

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic [IDX_W:0]    cand;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
         if (cand >= NREQ_X) cand = cand - NREQ_X;
         if (!pick_found && i_req_valid[cand[IDX_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      cnt_d       = cnt_q;
      ready_d     = '0;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      spi_data_d  = spi_data_q;
      spi_cfg_d   = spi_cfg_q;
      trans_en_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               ready_d = ONE_HOT0 << pick_idx;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            // Requester holds its word through GRANT, so sample at the closing edge.
            spi_data_d = req_data[grant_q];
            spi_cfg_d  = req_cfg[grant_q];
            rr_ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
            state_d    = S_SETUP;
         end
         S_SETUP: begin
            cnt_d      = '0;
            trans_en_d = 1'b1;
            state_d    = S_BUSY;
         end
         S_BUSY: begin
            trans_en_d = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            if (i_spi_interrupt) begin
               rsp_data_d  = i_spi_data;
               rsp_err_d   = 1'b0;
               rsp_valid_d = ONE_HOT0 << grant_q;
               trans_en_d  = 1'b0;
               state_d     = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = ONE_HOT0 << grant_q;
               trans_en_d  = 1'b0;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         cnt_q       <= '0;
         ready_q     <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         spi_data_q  <= '0;
         spi_cfg_q   <= '0;
         trans_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         spi_data_q  <= spi_data_d;
         spi_cfg_q   <= spi_cfg_d;
         trans_en_q  <= trans_en_d;
      end
   end

   assign o_req_ready    = ready_q;
   assign o_rsp_valid    = rsp_valid_q;
   assign o_rsp_data     = rsp_data_q;
   assign o_rsp_err      = rsp_err_q;
   assign o_busy         = busy_q;
   assign o_spi_data     = spi_data_q;
   assign o_spi_config   = spi_cfg_q;
   assign o_spi_trans_en = trans_en_q;

endmodule
